// File: rtl/reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reset_sequencer                                                          |
// | Filters MMCM lock, times the PHY reset, then releases NUM_CH domain      |
// | resets in index order. `RST_SEQ_LOCK_CNT_EN adds an 8-bit saturating     |
// | lock-loss counter output (lock_loss_count).                              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module reset_sequencer #(
    parameter int NUM_CH         = 3,
    parameter int SYNC_STAGES    = 4,
    parameter int LOCK_FILTER    = 64,
    parameter int PHY_RST_CYCLES = 1250,
    parameter int CH_DELAY       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pll_locked,
    input  logic              sw_rst_req,
    output logic              phy_reset_n,
    output logic [NUM_CH-1:0] rst_out,
    output logic              all_ready,
    output logic              busy
`ifdef RST_SEQ_LOCK_CNT_EN
    ,
    output logic [7:0]        lock_loss_count
`endif
);

    localparam int c_max_ab  = (LOCK_FILTER > PHY_RST_CYCLES) ? LOCK_FILTER : PHY_RST_CYCLES;
    localparam int c_cnt_max = (c_max_ab > CH_DELAY) ? c_max_ab : CH_DELAY;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam int c_idx_w   = $clog2(NUM_CH + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_lock_ld  = c_cnt_w'(LOCK_FILTER);
    localparam logic [c_cnt_w-1:0] c_phy_ld   = c_cnt_w'(PHY_RST_CYCLES);
    localparam logic [c_cnt_w-1:0] c_ch_ld    = c_cnt_w'(CH_DELAY);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NUM_CH - 1);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK   = 3'd0,
        ST_LOCK_STABLE = 3'd1,
        ST_PHY_RST     = 3'd2,
        ST_RELEASE     = 3'd3,
        ST_RUN         = 3'd4
    } state_t;

    state_t                  r_state;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [c_idx_w-1:0]      r_idx;
    logic                    r_phy_reset_n;
    logic [NUM_CH-1:0]       r_rst_out;
    logic                    r_all_ready;
    logic                    r_busy;
`ifdef RST_SEQ_LOCK_CNT_EN
    logic [7:0]              r_lock_cnt;
`endif

    logic w_lock_s;
    logic w_cnt_last;
    logic w_sw_ok;

    assign w_lock_s   = r_sync[SYNC_STAGES-1];
    assign w_cnt_last = (r_cnt == c_cnt_one);
    assign w_sw_ok    = (r_state == ST_PHY_RST) || (r_state == ST_RELEASE) || (r_state == ST_RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_WAIT_LOCK;
            r_sync        <= '0;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_phy_reset_n <= 1'b0;
            r_rst_out     <= '1;
            r_all_ready   <= 1'b0;
            r_busy        <= 1'b1;
`ifdef RST_SEQ_LOCK_CNT_EN
            r_lock_cnt    <= 8'd0;
`endif
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};

            // Lock loss outranks a software request and every state transition.
            if ((r_state != ST_WAIT_LOCK) && !w_lock_s) begin
                r_state       <= ST_WAIT_LOCK;
                r_cnt         <= '0;
                r_idx         <= '0;
                r_phy_reset_n <= 1'b0;
                r_rst_out     <= '1;
                r_all_ready   <= 1'b0;
                r_busy        <= 1'b1;
`ifdef RST_SEQ_LOCK_CNT_EN
                if (r_lock_cnt != 8'hFF) begin
                    r_lock_cnt <= r_lock_cnt + 8'd1;
                end
`endif
            end else if (sw_rst_req && w_sw_ok) begin
                r_state       <= ST_PHY_RST;
                r_cnt         <= c_phy_ld;
                r_idx         <= '0;
                r_phy_reset_n <= 1'b0;
                r_rst_out     <= '1;
                r_all_ready   <= 1'b0;
                r_busy        <= 1'b1;
            end else begin
                case (r_state)
                    ST_WAIT_LOCK: begin
                        if (w_lock_s) begin
                            r_state <= ST_LOCK_STABLE;
                            r_cnt   <= c_lock_ld;
                        end
                    end
                    ST_LOCK_STABLE: begin
                        if (w_cnt_last) begin
                            r_state <= ST_PHY_RST;
                            r_cnt   <= c_phy_ld;
                        end else begin
                            r_cnt <= r_cnt - c_cnt_one;
                        end
                    end
                    ST_PHY_RST: begin
                        if (w_cnt_last) begin
                            r_state       <= ST_RELEASE;
                            r_phy_reset_n <= 1'b1;
                            r_cnt         <= c_ch_ld;
                            r_idx         <= '0;
                        end else begin
                            r_cnt <= r_cnt - c_cnt_one;
                        end
                    end
                    ST_RELEASE: begin
                        if (w_cnt_last) begin
                            // Bits are cleared strictly from bit 0 upward, so a shift suffices.
                            r_rst_out <= r_rst_out << 1;
                            r_idx     <= r_idx + c_idx_one;
                            r_cnt     <= c_ch_ld;
                            if (r_idx == c_idx_last) begin
                                r_state     <= ST_RUN;
                                r_all_ready <= 1'b1;
                                r_busy      <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt - c_cnt_one;
                        end
                    end
                    ST_RUN: begin
                        r_all_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_WAIT_LOCK;
                    end
                endcase
            end
        end
    end

    assign phy_reset_n = r_phy_reset_n;
    assign rst_out     = r_rst_out;
    assign all_ready   = r_all_ready;
    assign busy        = r_busy;
`ifdef RST_SEQ_LOCK_CNT_EN
    assign lock_loss_count = r_lock_cnt;
`endif

endmodule
`default_nettype wire
